// File: rtl/pixel_pkg.sv
// pixel_pkg: shared screen geometry, address width, FSM state and FIFO entry layout
package pixel_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W = 15;
  typedef enum logic {IDLE, CLEAR} state_t;
  // In-range rows are below 128, so 7 bits of y suffice and an entry packs into 18 bits.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_t;
endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: DEPTH-entry synchronous show-ahead FIFO with full/empty flags
// Ports: clock, reset_n (async, active-low), i_push/i_data write side,
// i_pop/o_data read side (o_data is the head entry), o_full, o_empty.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 18
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
    end
endmodule

// File: rtl/pixel_plot_receiver.sv
// pixel_plot_receiver: queues pixel plots and full-screen clears into framebuffer writes
// Ports: clock, reset_n (async, active-low); plot/x/y/colour with ready handshake;
// clear/clear_colour fill request; fb_addr/fb_data/fb_we registered write port;
// busy while work remains; dropped counts rejected off-screen plots (saturating).
module pixel_plot_receiver
  import pixel_pkg::state_t, pixel_pkg::IDLE, pixel_pkg::CLEAR, pixel_pkg::ADDR_W, pixel_pkg::plot_t;
#(
  parameter int DEPTH = 8,
  parameter int SCREEN_W = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [2:0]        colour,
  output logic              ready,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              fb_we,
  output logic              busy,
  output logic [7:0]        dropped
);
  localparam logic [8:0] LW = 9'(SCREEN_W);
  localparam logic [8:0] LH = 9'(SCREEN_H);
  localparam logic [ADDR_W-1:0] SW = ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  state_t r_state;
  logic r_clear_pending, r_fb_we;
  logic [2:0] r_clear_colour, r_fb_data;
  logic [ADDR_W-1:0] r_sweep, r_fb_addr;
  logic [7:0] r_dropped;
  logic w_full, w_empty, w_accept, w_in_range, w_push, w_reject, w_pop, w_last;
  plot_t w_head, w_entry;
  logic [ADDR_W-1:0] w_addr;
  // reset_n gates ready so it reads low while reset is held, high in the first cycle after.
  assign ready = reset_n && !w_full && !r_clear_pending && r_state != CLEAR;
  assign w_accept = plot && ready;
  assign w_in_range = ({1'b0, x} < LW) && ({1'b0, y} < LH);
  assign w_push = w_accept && w_in_range;
  assign w_reject = w_accept && !w_in_range;
  assign w_pop = r_state == IDLE && !w_empty;
  assign w_last = r_sweep == LAST;
  assign w_entry = '{x: x, y: y[6:0], colour: colour};
  assign w_addr = ADDR_W'(w_head.y) * SW + ADDR_W'(w_head.x);
  assign busy = !w_empty || r_clear_pending || r_state == CLEAR;
  assign fb_addr = r_fb_addr;
  assign fb_data = r_fb_data;
  assign fb_we = r_fb_we;
  assign dropped = r_dropped;
  plot_fifo #(.DEPTH(DEPTH), .W($bits(plot_t))) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .i_push (w_push),
    .i_data (w_entry),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_clear_pending <= 1'b0;
      r_clear_colour <= '0;
      r_sweep <= '0;
      r_fb_we <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_dropped <= '0;
    end else begin
      r_dropped <= (w_reject && r_dropped != 8'hFF) ? r_dropped + 8'd1 : r_dropped;
      // Pending stays set through the whole sweep, so this also ignores clears during CLEAR.
      if (clear && !r_clear_pending) begin
        r_clear_pending <= 1'b1;
        r_clear_colour <= clear_colour;
      end
      r_fb_we <= w_pop || r_state == CLEAR;
      if (r_state == CLEAR) begin
        r_fb_addr <= r_sweep;
        r_fb_data <= r_clear_colour;
        r_sweep <= w_last ? '0 : r_sweep + 1'b1;
        if (w_last) begin
          r_state <= IDLE;
          r_clear_pending <= 1'b0;
        end
      end else begin
        if (w_pop) begin
          r_fb_addr <= w_addr;
          r_fb_data <= w_head.colour;
        end
        // Queued plots drain before the sweep starts.
        if (r_clear_pending && w_empty) r_state <= CLEAR;
      end
    end
endmodule

// File: tb/tb_pixel_plot_receiver.sv
// tb_pixel_plot_receiver: randomized and directed checks against a write-order scoreboard
module tb_pixel_plot_receiver;
  localparam int W = 160;
  localparam int H = 120;
  localparam int LAST = W * H - 1;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic plot = 1'b0;
  logic clear = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] colour = '0;
  logic [2:0] clear_colour = '0;
  logic ready, fb_we, busy;
  logic [14:0] fb_addr;
  logic [2:0] fb_data;
  logic [7:0] dropped;
  typedef struct packed {
    logic sw;
    logic [14:0] a;
    logic [2:0] d;
  } wr_t;
  wr_t q[$];
  wr_t last_w = '0;
  bit pend = 0;
  int drop_m = 0;
  int n_vec = 0;
  int n_err = 0;
  pixel_plot_receiver dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .ready       (ready),
    .clear       (clear),
    .clear_colour(clear_colour),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .busy        (busy),
    .dropped     (dropped)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic monitor();
    if (fb_we) begin
      if (q.size() == 0) chk("spurious_we", 32'(fb_we), 0);
      else begin
        last_w = q.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(last_w.a));
        chk("fb_data", 32'(fb_data), 32'(last_w.d));
        if (last_w.sw && last_w.a == 15'(LAST)) pend = 0;
      end
    end else begin
      chk("hold_addr", 32'(fb_addr), 32'(last_w.a));
      chk("hold_data", 32'(fb_data), 32'(last_w.d));
    end
    chk("dropped", 32'(dropped), 32'(drop_m));
    if (pend) begin
      chk("ready_pend", 32'(ready), 0);
      chk("busy_pend", 32'(busy), 1);
    end else if (q.size() == 0) chk("busy_idle", 32'(busy), 0);
  endtask
  task automatic cyc(input bit p, input int px, input int py, input int pc, input bit cl = 0, input int cc = 0);
    plot = p;
    x = 8'(px);
    y = 8'(py);
    colour = 3'(pc);
    clear = cl;
    clear_colour = 3'(cc);
    if (p && ready === 1'b1) begin
      if (px < W && py < H) q.push_back('{1'b0, 15'(py * W + px), 3'(pc)});
      else if (drop_m < 255) drop_m++;
    end
    if (cl && !pend && reset_n) begin
      pend = 1;
      for (int i = 0; i <= LAST; i++) q.push_back('{1'b1, 15'(i), 3'(cc)});
    end
    @(negedge clock);
    monitor();
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((q.size() != 0 || pend) && n < lim) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    if (q.size() != 0 || pend) chk("drain_timeout", 32'(q.size()), 0);
    repeat (3) cyc(0, 0, 0, 0);
  endtask
  initial begin
    int k, n;
    bit a;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_dropped", 32'(dropped), 0);
    reset_n = 1'b1;
    #1 chk("ready_after_rst", 32'(ready), 1);
    @(negedge clock);
    cyc(1, 3, 2, 7);
    chk("lat_n1", 32'(fb_we), 0);
    cyc(0, 0, 0, 0);
    chk("lat_n2_we", 32'(fb_we), 1);
    chk("lat_n2_addr", 32'(fb_addr), 323);
    cyc(0, 0, 0, 0);
    chk("lat_n3", 32'(fb_we), 0);
    cyc(1, 160, 0, 1);
    cyc(1, 0, 120, 1);
    cyc(1, 255, 255, 1);
    repeat (2) cyc(0, 0, 0, 0);
    chk("dropped3", 32'(dropped), 3);
    repeat (256) cyc(1, 200, 5, 0);
    repeat (2) cyc(0, 0, 0, 0);
    chk("dropped_sat", 32'(dropped), 255);
    k = 0;
    n = 0;
    while (k < 20 && n < 200) begin
      a = ready;
      cyc(1, k, 119, 5);
      if (a) k++;
      n++;
    end
    chk("burst_accepts", 32'(k), 20);
    drain(100);
    cyc(1, 10, 10, 1);
    cyc(1, 11, 20, 3);
    cyc(1, 159, 119, 4);
    cyc(0, 0, 0, 0, 1, 2);
    repeat (5) cyc(1, 1, 1, 6, 1, 5);
    drain(25000);
    chk("ready_after_sweep", 32'(ready), 1);
    cyc(0, 0, 0, 0, 1, 6);
    n = 0;
    while (!(last_w.sw && last_w.a == 15'd5000) && n < 25000) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("sweep_reach_5000", 32'(last_w.a), 5000);
    reset_n = 1'b0;
    #1;
    chk("abort_we", 32'(fb_we), 0);
    chk("abort_ready", 32'(ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dropped", 32'(dropped), 0);
    q.delete();
    pend = 0;
    drop_m = 0;
    last_w = '0;
    @(negedge clock);
    repeat (2) cyc(0, 0, 0, 0);
    reset_n = 1'b1;
    #1 chk("ready_rerelease", 32'(ready), 1);
    cyc(1, 1, 1, 4);
    drain(20);
    cyc(1, 5, 6, 3, 1, 1);
    cyc(0, 0, 0, 0);
    chk("same_cycle_plot_first", 32'(fb_addr), 965);
    drain(25000);
    for (int i = 0; i < 800; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 170), $urandom_range(0, 125),
          $urandom_range(0, 7), i == 400, $urandom_range(0, 7));
    drain(25000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
